// File: rtl/segment_animator_if.sv
// Control and display bundle for the segment animator.
// The bench or system drives the master side; the animator is the slave.
interface segment_animator_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic                    restart;
    logic [1:0]              mode;
    logic [8*NUM_DIGITS-1:0] seg_n;
    logic [POS_W-1:0]        pos;
    logic                    frame_stb;
    logic                    cycle_done;

    modport master (
        output enable, restart, mode,
        input  seg_n, pos, frame_stb, cycle_done
    );

    modport slave (
        input  enable, restart, mode,
        output seg_n, pos, frame_stb, cycle_done
    );
endinterface

// File: rtl/segment_animator.sv
// Self-running 7-segment liveness animation: chase, bounce and mirror
// modes with tick/dwell frame timing and an optional blank gap.
module segment_animator #(
    parameter int         NUM_DIGITS = 4,
    parameter int         TICK_DIV   = 1389000,
    parameter int         DWELL      = 4,
    parameter int         GAP_FRAMES = 2,
    parameter logic [7:0] PAT_A      = 8'b1100_1111,
    parameter logic [7:0] PAT_B      = 8'b1111_1001
) (
    input logic               clk,
    input logic               reset,
    segment_animator_if.slave bus
);
    localparam int POS_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int GAP_W   = 8;
    localparam int SEG_W   = 8 * NUM_DIGITS;

    localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(TICK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL - 1);
    localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_DIGITS - 1);
    localparam logic [POS_W-1:0]   POS_PEN   = POS_W'(NUM_DIGITS - 2);
    localparam logic [GAP_W-1:0]   GAP_MAX   =
        GAP_W'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [TICK_W-1:0]  r_tick;
    logic [DWELL_W-1:0] r_dwell;
    logic [POS_W-1:0]   r_pos;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic [GAP_W-1:0]   r_gap;
    logic [SEG_W-1:0]   r_seg;
    logic               r_stb;
    logic               r_done;

    state_t             w_state_nxt;
    logic [TICK_W-1:0]  w_tick_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [POS_W-1:0]   w_pos_nxt;
    logic               w_dir_nxt;
    logic [1:0]         w_mode_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [SEG_W-1:0]   w_seg_nxt;
    logic               w_stb_nxt;
    logic               w_done_nxt;

    logic               w_tick;
    logic               w_fa;
    logic               w_enter;
    logic               w_end;
    logic               w_bounce;
    logic [7:0]         w_glyph;

    assign w_tick   = (r_tick == TICK_MAX);
    assign w_fa     = w_tick && (r_dwell == DWELL_MAX);
    assign w_bounce = (r_mode == 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_dwell_nxt = r_dwell;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = r_mode;
        w_gap_nxt   = r_gap;
        w_stb_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_enter     = 1'b0;
        w_end       = 1'b0;

        if (bus.restart) begin
            w_enter = 1'b1;
        end else if (bus.enable) begin
            unique case (r_state)
                S_IDLE: w_enter = 1'b1;
                S_RUN, S_GAP: begin
                    w_tick_nxt = w_tick ? '0 : r_tick + 1'b1;
                    if (w_tick)
                        w_dwell_nxt = w_fa ? '0 : r_dwell + 1'b1;
                    if (w_fa) begin
                        w_stb_nxt = 1'b1;
                        if (r_state == S_RUN) begin
                            if (w_bounce && r_dir) begin
                                if (r_pos == POS_W'(1))
                                    w_end = 1'b1;
                                else
                                    w_pos_nxt = r_pos - 1'b1;
                            end else if (w_bounce) begin
                                w_pos_nxt = r_pos + 1'b1;
                                if (r_pos == POS_PEN)
                                    w_dir_nxt = 1'b1;
                            end else if (r_pos == POS_MAX) begin
                                w_end = 1'b1;
                            end else begin
                                w_pos_nxt = r_pos + 1'b1;
                            end
                        end else if (r_gap == GAP_MAX) begin
                            w_enter = 1'b1;
                        end else begin
                            w_gap_nxt = r_gap + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_end) begin
            w_done_nxt = 1'b1;
            if (GAP_FRAMES > 0) begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = '0;
                w_pos_nxt   = '0;
                w_dir_nxt   = 1'b0;
            end else begin
                w_enter = 1'b1;
            end
        end

        // Every entry into RUN restarts timing and picks up the new mode.
        if (w_enter) begin
            w_state_nxt = S_RUN;
            w_tick_nxt  = '0;
            w_dwell_nxt = '0;
            w_pos_nxt   = '0;
            w_dir_nxt   = 1'b0;
            w_gap_nxt   = '0;
            w_mode_nxt  = bus.mode;
            w_stb_nxt   = 1'b1;
        end
    end

    always_comb begin
        w_seg_nxt = '1;
        w_glyph   = 8'hFF;
        if (w_state_nxt == S_RUN) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                w_glyph = 8'hFF;
                if (POS_W'(k) == w_pos_nxt)
                    w_glyph = w_glyph & PAT_A;
                if ((w_mode_nxt == 2'd2) &&
                    (POS_W'(NUM_DIGITS - 1 - k) == w_pos_nxt))
                    w_glyph = w_glyph & PAT_B;
                w_seg_nxt[8*k +: 8] = w_glyph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_dwell <= '0;
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 2'd0;
            r_gap   <= '0;
            r_seg   <= '1;
            r_stb   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_dwell <= w_dwell_nxt;
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
            r_mode  <= w_mode_nxt;
            r_gap   <= w_gap_nxt;
            r_seg   <= w_seg_nxt;
            r_stb   <= w_stb_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.seg_n      = r_seg;
    assign bus.pos        = r_pos;
    assign bus.frame_stb  = r_stb;
    assign bus.cycle_done = r_done;
endmodule

// File: tb/tb_segment_animator.sv
// Randomized bench for segment_animator: two instances checked every
// cycle against a frame-index model, plus hand-computed glyph checks.
module tb_segment_animator;
    localparam int NA = 4, TDA = 2, DWA = 3, GA = 2;
    localparam int NB = 5, TDB = 1, DWB = 2, GB = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] mode = 2'd0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    segment_animator_if #(.NUM_DIGITS(NA)) ifa ();
    segment_animator_if #(.NUM_DIGITS(NB)) ifb ();

    assign ifa.enable  = enable;
    assign ifa.restart = restart;
    assign ifa.mode    = mode;
    assign ifb.enable  = enable;
    assign ifb.restart = restart;
    assign ifb.mode    = mode;

    segment_animator #(
        .NUM_DIGITS(NA), .TICK_DIV(TDA), .DWELL(DWA), .GAP_FRAMES(GA)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

    segment_animator #(
        .NUM_DIGITS(NB), .TICK_DIV(TDB), .DWELL(DWB), .GAP_FRAMES(GB)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    function automatic int p_n(int i);  return i == 0 ? NA : NB; endfunction
    function automatic int p_fl(int i); return i == 0 ? TDA * DWA : TDB * DWB; endfunction
    function automatic int p_g(int i);  return i == 0 ? GA : GB; endfunction

    function automatic int cyc_len(int n, int m);
        return (m == 1) ? 2 * n - 2 : n;
    endfunction

    function automatic int fpos(int n, int m, int f);
        if (m == 1 && f >= n) return 2 * n - 2 - f;
        return f;
    endfunction

    function automatic logic [63:0] fseg(int n, int m, int f, int a);
        logic [63:0] s;
        logic [7:0]  g;
        int          p;
        s = '0;
        p = fpos(n, m, f);
        for (int k = 0; k < n; k++) begin
            g = 8'hFF;
            if (a != 0 && f < cyc_len(n, m)) begin
                if (k == p) g = g & 8'hCF;
                if (m == 2 && k == n - 1 - p) g = g & 8'hF9;
            end
            s[8*k +: 8] = g;
        end
        return s;
    endfunction

    // Model: active flag, enabled clocks into the frame, frame index in
    // the run+gap period, and latched mode.
    int act[2] = '{0, 0};
    int cc[2]  = '{0, 0};
    int fr[2]  = '{0, 0};
    int ml[2]  = '{0, 0};
    bit es[2]  = '{0, 0};
    bit ed[2]  = '{0, 0};

    task automatic step(int i);
        int len;
        es[i] = 1'b0;
        ed[i] = 1'b0;
        if (reset) begin
            act[i] = 0; cc[i] = 0; fr[i] = 0; ml[i] = 0;
        end else if (restart || (enable && act[i] == 0)) begin
            act[i] = 1; cc[i] = 0; fr[i] = 0;
            ml[i] = (mode == 2'd3) ? 0 : int'(mode);
            es[i] = 1'b1;
        end else if (enable) begin
            cc[i]++;
            if (cc[i] == p_fl(i)) begin
                cc[i] = 0;
                es[i] = 1'b1;
                fr[i]++;
                len = cyc_len(p_n(i), ml[i]);
                if (fr[i] == len) ed[i] = 1'b1;
                if (fr[i] == len + p_g(i)) begin
                    fr[i] = 0;
                    ml[i] = (mode == 2'd3) ? 0 : int'(mode);
                end
            end
        end
    endtask

    always @(posedge clk)
        for (int i = 0; i < 2; i++) step(i);

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] sg;
        logic [63:0] ps;
        logic        st, dn;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                sg = 64'(ifa.seg_n); ps = 64'(ifa.pos);
                st = ifa.frame_stb;  dn = ifa.cycle_done;
            end else begin
                sg = 64'(ifb.seg_n); ps = 64'(ifb.pos);
                st = ifb.frame_stb;  dn = ifb.cycle_done;
            end
            chk($sformatf("seg%0d", i), sg, fseg(p_n(i), ml[i], fr[i], act[i]));
            chk($sformatf("stb%0d", i), 64'(st), 64'(es[i]));
            chk($sformatf("done%0d", i), 64'(dn), 64'(ed[i]));
            if (act[i] != 0 && fr[i] < cyc_len(p_n(i), ml[i]))
                chk($sformatf("pos%0d", i), ps,
                    64'(fpos(p_n(i), ml[i], fr[i])));
        end
    end

    initial begin
        int frz;
        frz = 0;
        repeat (2) @(negedge clk);
        chk("lit_reset_a", 64'(ifa.seg_n), 64'hFFFF_FFFF);
        #1 reset = 1'b0; enable = 1'b1;
        @(negedge clk);
        chk("lit_first_a", 64'(ifa.seg_n), 64'hFFFF_FFCF);
        chk("lit_first_stb", 64'(ifa.frame_stb), 64'd1);
        repeat (6) @(negedge clk);
        chk("lit_second_a", 64'(ifa.seg_n), 64'hFFFF_CFFF);
        #1 mode = 2'd2; restart = 1'b1;
        @(negedge clk);
        chk("lit_mir0_b", 64'(ifb.seg_n), 64'hF9_FFFF_FFCF);
        chk("lit_mir0_a", 64'(ifa.seg_n), 64'hF9FF_FFCF);
        #1 restart = 1'b0;
        repeat (4) @(negedge clk);
        chk("lit_mir2_b", 64'(ifb.seg_n), 64'hFF_FFC9_FFFF);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("lit_rst_a", 64'(ifa.seg_n), 64'hFFFF_FFFF);
        #1 reset = 1'b0; mode = 2'd1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            #1;
            if (frz > 0) begin
                enable = 1'b0;
                frz--;
            end else begin
                enable = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 199) == 0) frz = 10;
            end
            restart = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 1499) == 0);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
